// File: rtl/seq_pkg.sv
// Shared encodings for the microprogram sequencer slice.
// Optional build macro: SEQ_OVF_GUARD_EN (stack overflow guard).
package seq_pkg;

  localparam logic [3:0] I_JZ   = 4'd0;
  localparam logic [3:0] I_CJS  = 4'd1;
  localparam logic [3:0] I_JMAP = 4'd2;
  localparam logic [3:0] I_CJP  = 4'd3;
  localparam logic [3:0] I_PUSH = 4'd4;
  localparam logic [3:0] I_JSRP = 4'd5;
  localparam logic [3:0] I_CJV  = 4'd6;
  localparam logic [3:0] I_JRP  = 4'd7;
  localparam logic [3:0] I_RFCT = 4'd8;
  localparam logic [3:0] I_RPCT = 4'd9;
  localparam logic [3:0] I_CRTN = 4'd10;
  localparam logic [3:0] I_CJPP = 4'd11;
  localparam logic [3:0] I_LDCT = 4'd12;
  localparam logic [3:0] I_LOOP = 4'd13;
  localparam logic [3:0] I_CONT = 4'd14;
  localparam logic [3:0] I_TWB  = 4'd15;

  localparam logic [1:0] OP_HOLD  = 2'b00;
  localparam logic [1:0] OP_PUSH  = 2'b01;
  localparam logic [1:0] OP_POP   = 2'b10;
  localparam logic [1:0] OP_RESET = 2'b11;

  typedef enum logic [2:0] {
    YS_D, YS_R, YS_F, YS_PC, YS_ZERO
  } ysel_e;

  typedef enum logic [1:0] {
    R_HOLD, R_LOAD, R_DEC
  } rop_e;

  typedef struct packed {
    ysel_e      ysel;
    logic [1:0] sop;
    rop_e       rop;
    logic       pl_n;
    logic       map_n;
    logic       vect_n;
  } dec_t;

endpackage

// File: rtl/seq_stack_if.sv
// Bus between the sequencer controller and the external 5-deep stack.
// Controller side is master; the stack block is slave.
interface seq_stack_if #(
  parameter int AW = 12
) ();
  logic [1:0]    stack_op;
  logic [AW-1:0] stack_din;
  logic [AW-1:0] stack_dout;
  logic          stack_full_n;

  modport master (
    output stack_op, stack_din,
    input  stack_dout, stack_full_n
  );

  modport slave (
    input  stack_op, stack_din,
    output stack_dout, stack_full_n
  );
endinterface

// File: rtl/seq_decode.sv
// Combinational instruction decode for the sequencer.
// Maps opcode, condition pass and R!=0 onto the datapath controls.
module seq_decode
  import seq_pkg::*;
(
  input  logic [3:0] i,
  input  logic       pass,
  input  logic       rnz,
  output dec_t       dec
);

  always_comb begin
    dec = '{ysel: YS_PC, sop: OP_HOLD, rop: R_HOLD,
            pl_n: 1'b0, map_n: 1'b1, vect_n: 1'b1};
    unique case (1'b1)
      (i == I_JZ): begin
        dec.ysel = YS_ZERO;
        dec.sop  = OP_RESET;
      end
      (i == I_CJS): if (pass) begin
        dec.ysel = YS_D;
        dec.sop  = OP_PUSH;
      end
      (i == I_JMAP): begin
        dec.ysel  = YS_D;
        dec.pl_n  = 1'b1;
        dec.map_n = 1'b0;
      end
      (i == I_CJP): if (pass) dec.ysel = YS_D;
      (i == I_PUSH): begin
        dec.sop = OP_PUSH;
        if (pass) dec.rop = R_LOAD;
      end
      (i == I_JSRP): begin
        dec.ysel = pass ? YS_D : YS_R;
        dec.sop  = OP_PUSH;
      end
      (i == I_CJV): begin
        if (pass) dec.ysel = YS_D;
        dec.pl_n   = 1'b1;
        dec.vect_n = 1'b0;
      end
      (i == I_JRP): dec.ysel = pass ? YS_D : YS_R;
      (i == I_RFCT): begin
        if (rnz) begin
          dec.ysel = YS_F;
          dec.rop  = R_DEC;
        end else begin
          dec.sop = OP_POP;
        end
      end
      (i == I_RPCT): if (rnz) begin
        dec.ysel = YS_D;
        dec.rop  = R_DEC;
      end
      (i == I_CRTN): if (pass) begin
        dec.ysel = YS_F;
        dec.sop  = OP_POP;
      end
      (i == I_CJPP): if (pass) begin
        dec.ysel = YS_D;
        dec.sop  = OP_POP;
      end
      (i == I_LDCT): dec.rop = R_LOAD;
      (i == I_LOOP): begin
        if (pass) dec.sop = OP_POP;
        else dec.ysel = YS_F;
      end
      (i == I_CONT): dec.ysel = YS_PC;
      (i == I_TWB): begin
        if (pass) begin
          dec.sop = OP_POP;
        end else if (rnz) begin
          dec.ysel = YS_F;
          dec.rop  = R_DEC;
        end else begin
          dec.ysel = YS_D;
          dec.sop  = OP_POP;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/seq_ctrl.sv
// Next-address controller: microPC, register/counter, Y mux, stack sequencing.
// Build option SEQ_OVF_GUARD_EN turns push-on-full into HOLD plus sticky ovf_err.
module seq_ctrl
  import seq_pkg::*;
#(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    i,
  input  logic [AW-1:0] d,
  input  logic          cc_n,
  input  logic          ccen_n,
  input  logic          rld_n,
  input  logic          ci,
  output logic [AW-1:0] y,
  output logic          pl_n,
  output logic          map_n,
  output logic          vect_n,
  seq_stack_if.master   stk,
  output logic          full_n,
  output logic          ovf_err
);

  logic [AW-1:0] pc;
  logic [AW-1:0] r;
  logic [AW-1:0] ymux;
  logic [AW-1:0] r_nxt;
  logic          pass;
  logic          rnz;
  logic          ovf_hit;
  dec_t          dec;

  assign pass = ccen_n | ~cc_n;
  assign rnz  = |r;

  seq_decode u_dec (
    .i    (i),
    .pass (pass),
    .rnz  (rnz),
    .dec  (dec)
  );

  always_comb begin
    ymux = pc;
    unique case (dec.ysel)
      YS_D:    ymux = d;
      YS_R:    ymux = r;
      YS_F:    ymux = stk.stack_dout;
      YS_PC:   ymux = pc;
      YS_ZERO: ymux = '0;
      default: ymux = pc;
    endcase
  end

  // Reset forces a quiet bus and a stack clear, independent of decode.
  assign y      = rst_n ? ymux : '0;
  assign pl_n   = rst_n ? dec.pl_n : 1'b1;
  assign map_n  = rst_n ? dec.map_n : 1'b1;
  assign vect_n = rst_n ? dec.vect_n : 1'b1;
  assign full_n = stk.stack_full_n;

  assign stk.stack_din = pc;
  assign stk.stack_op  = !rst_n  ? OP_RESET :
                         ovf_hit ? OP_HOLD  : dec.sop;

  always_comb begin
    r_nxt = r;
    if (!rld_n) begin
      r_nxt = d;
    end else begin
      unique case (dec.rop)
        R_LOAD:  r_nxt = d;
        R_DEC:   r_nxt = r - 1'b1;
        default: r_nxt = r;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= '0;
      r  <= '0;
    end else begin
      pc <= y + {{(AW-1){1'b0}}, ci};
      r  <= r_nxt;
    end
  end

`ifdef SEQ_OVF_GUARD_EN
  logic ovf_q;

  assign ovf_hit = (dec.sop == OP_PUSH) & ~stk.stack_full_n;
  assign ovf_err = ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else if (ovf_hit) ovf_q <= 1'b1;
  end
`else
  assign ovf_hit = 1'b0;
  assign ovf_err = 1'b0;
`endif

endmodule

// File: doc/seq_ctrl.md
# seq_ctrl

Next-address controller for the microprogram sequencer. It decodes the 4-bit sequencer instruction and the condition inputs, and from them selects the next microaddress from D, the register/counter, the microPC or the top of stack. It owns the microPC and the register/counter, and sequences the external 5-deep `stack` block through its `stack_op` port. It sits between the pipeline register (instruction, D, condition) and the control store address bus.

## Interface
- `AW`, 12, address/data width of microPC, register/counter, D, Y and stack data.
- `clk`  in  1  rising-edge clock; shared with the `stack` block.
- `rst_n`  in  1  asynchronous, active-low reset.
- `i`  in  4  sequencer instruction (0..15).
- `d`  in  AW  direct branch address / counter load value.
- `cc_n`  in  1  condition code, active low.
- `ccen_n`  in  1  condition enable, active low.
- `rld_n`  in  1  forced register/counter load, active low.
- `ci`  in  1  microPC increment carry.
- `y`  out  AW  next microaddress (combinational).
- `pl_n`, `map_n`, `vect_n`  out  1 each  source enables, active low, one-hot low.
- `stack_op`  out  2  00 HOLD, 01 PUSH, 10 POP, 11 RESET.
- `stack_din`  out  AW  push data; always equals microPC.
- `stack_dout`  in  AW  top of stack (F).
- `stack_full_n`  in  1  stack full, active low.
- `full_n`  out  1  pass-through of `stack_full_n`.
- `ovf_err`  out  1  sticky push-on-full flag (see Configuration).

## Operation
- Condition pass: `pass = ccen_n | ~cc_n`.
- R = register/counter, F = `stack_dout`, PC = microPC. "dec" means R <= R-1.
- Instruction table. Format: Y; stack; R.
  - 0 JZ: 0; RESET; hold.
  - 1 CJS: pass ? D, PUSH : PC, HOLD.
  - 2 JMAP: D; HOLD; `map_n` low.
  - 3 CJP: pass ? D : PC.
  - 4 PUSH: PC; PUSH; load D if pass.
  - 5 JSRP: pass ? D : R; PUSH.
  - 6 CJV: pass ? D : PC; `vect_n` low.
  - 7 JRP: pass ? D : R.
  - 8 RFCT: R≠0 ? F, dec : PC, POP.
  - 9 RPCT: R≠0 ? D, dec : PC.
  - 10 CRTN: pass ? F, POP : PC.
  - 11 CJPP: pass ? D, POP : PC.
  - 12 LDCT: PC; load D.
  - 13 LOOP: pass ? PC, POP : F.
  - 14 CONT: PC.
  - 15 TWB: R≠0: pass ? PC, POP : F, dec; R=0: pass ? PC, POP : D, POP.
- `pl_n` is low for every instruction except 2 and 6.
- `rld_n` low loads R with D. This overrides any dec or hold in the same cycle.
- R is never decremented at 0, so there is no wrap. PC <= Y + `ci`, modulo 2^AW.
- The controller does not guard POP on an empty stack. The stack holds its pointer, and F is undefined in that case.

## Timing
- `y`, enables and `stack_op` are combinational from inputs and registers, with zero latency.
- PC, R, `ovf_err` and stack contents update at the `clk` edge that ends the cycle.
- While `rst_n` is low:
  - PC=0, R=0, `ovf_err`=0.
  - `y`=0.
  - `pl_n`/`map_n`/`vect_n`=1.
  - `stack_op`=RESET, so the stack clears on any edge during reset. Reset must be held across at least one `clk` edge.
- Reset asserted mid-operation aborts immediately, and no pending push or pop completes after assertion.
- The first cycle after release decodes normally from PC=0.

## Configuration
- `SEQ_OVF_GUARD_EN` defined:
  - A PUSH while `stack_full_n`=0 is converted to HOLD.
  - `ovf_err` sets and stays set until reset.
  - Y and R behave as if the push happened.
- `SEQ_OVF_GUARD_EN` undefined:
  - PUSH is issued regardless, and the stack ignores it.
  - `ovf_err` is tied 0.

## Structure
- Package `seq_pkg` holds:
  - instruction opcode localparams (JZ..TWB);
  - `stack_op` encodings HOLD/PUSH/POP/RESET;
  - Y-source select encoding (D, R, F, PC, ZERO).
- Sub-module `seq_decode` is purely combinational. It maps `i`, `pass`, R≠0 to Y-source select, `stack_op`, R-op (hold/load/dec) and the three enables.
- The top level holds PC, R, the Y mux, the incrementer and the overflow guard.

## Test plan
- Reset with `i`=14 and pulse `rst_n` low across 2 edges:
  - `y`=0 and `stack_op`=11 during reset.
  - After release, `y` steps 0,1,2 with `ci`=1.
- CJS with D=0x123 at PC=0x010 and `ccen_n`=0 `cc_n`=0:
  - `y`=0x123 and `stack_op`=01 with `stack_din`=0x010.
  - CRTN next cycle gives `y`=0x010 with POP.
- LDCT with D=3, then RPCT D=0x200 three cycles:
  - `y`=0x200 three times (R 3→0).
  - Fourth RPCT gives `y`=PC.
- Push loop:
  - Six CJS pass with guard enabled: the sixth shows `stack_op`=00, `full_n`=0, `ovf_err`=1.
  - Without the guard: `stack_op`=01 and `ovf_err`=0.
- TWB:
  - With R=0, fail, D=0x3AB: `y`=0x3AB and POP.
  - With R=2, fail, F=0x055: `y`=0x055, R→1, HOLD.
- JMAP: `map_n`=0, `pl_n`=1.
- CJV: `vect_n`=0.
- `rld_n`=0 during RFCT with R=5: R loads D, no decrement.
